// File: rtl/spi_panel_ctrl_if.sv
// SPI slave <-> panel controller bus: frame/field strobes, panel fields,
// received byte and the byte returned to the slave.
interface spi_panel_ctrl_if;
    logic       spi_start;
    logic       spi_end;
    logic       kbd_received;
    logic       pnl_received;
    logic       data_received;
    logic [4:0] keypad;
    logic [3:0] out_sel;
    logic [3:0] in_sel;
    logic       key;
    logic       rst_cmd;
    logic       sel;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_ready;

    modport master (
        output spi_start, spi_end, kbd_received, pnl_received,
        output data_received, keypad, out_sel, in_sel,
        output key, rst_cmd, sel, data_in,
        input  data_out, data_ready
    );

    modport slave (
        input  spi_start, spi_end, kbd_received, pnl_received,
        input  data_received, keypad, out_sel, in_sel,
        input  key, rst_cmd, sel, data_in,
        output data_out, data_ready
    );
endinterface

// File: rtl/spi_panel_ctrl.sv
// SPI panel frame controller: header, channel byte load, payload, commit.
// Define SPI_CTRL_ABORT_CNT_EN to add the saturating abort_cnt output.
module spi_panel_ctrl #(
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    spi_panel_ctrl_if.slave  spi,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [8*NCH-1:0] ch_data,
    output logic [NCH-1:0]   ch_ack,
    output logic             wr_stb,
    output logic [3:0]       wr_ch,
    output logic [7:0]       wr_data,
    output logic             key_stb,
    output logic [4:0]       key_code,
    output logic             pnl_rst,
    output logic             pnl_sel,
    output logic             busy
`ifdef SPI_CTRL_ABORT_CNT_EN
    ,
    output logic [7:0]       abort_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        PAYLOAD,
        COMMIT
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           take_pnl;
    logic [4:0]     kbd_q;
    logic [3:0]     out_sel_q;
    logic [3:0]     in_sel_q;
    logic [7:0]     ld_byte;
    logic [NCH-1:0] ld_ack;

    // spi_start restarts any frame; spi_end aborts unless data wins
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (spi.pnl_received)   state_nx = LOAD;
                else if (spi.spi_start) state_nx = HDR;
            end
            HDR: begin
                if (spi.spi_start)         state_nx = HDR;
                else if (spi.spi_end)      state_nx = IDLE;
                else if (spi.pnl_received) state_nx = LOAD;
            end
            LOAD: begin
                if (spi.spi_start)    state_nx = HDR;
                else if (spi.spi_end) state_nx = IDLE;
                else                  state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                if (spi.spi_start)          state_nx = HDR;
                else if (spi.data_received) state_nx = COMMIT;
                else if (spi.spi_end)       state_nx = IDLE;
            end
            COMMIT: begin
                if (spi.spi_start) state_nx = HDR;
                else               state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign take_pnl = (state == IDLE || state == HDR) && (state_nx == LOAD);

    always_comb begin
        ld_byte = 8'h00;
        ld_ack  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (out_sel_q == 4'(i) && ch_valid[i]) begin
                ld_byte   = ch_data[8*i +: 8];
                ld_ack[i] = 1'b1;
            end
        end
    end

    assign ch_ack         = (state == LOAD && !reset) ? ld_ack : '0;
    assign spi.data_ready = (state == PAYLOAD);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            kbd_q        <= 5'h00;
            out_sel_q    <= 4'h0;
            in_sel_q     <= 4'h0;
            spi.data_out <= 8'h00;
            wr_stb       <= 1'b0;
            wr_ch        <= 4'h0;
            wr_data      <= 8'h00;
            key_stb      <= 1'b0;
            key_code     <= 5'h00;
            pnl_rst      <= 1'b0;
            pnl_sel      <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_stb  <= 1'b0;
            key_stb <= 1'b0;
            pnl_rst <= 1'b0;
            if (spi.kbd_received) kbd_q <= spi.keypad;
            if (take_pnl) begin
                out_sel_q <= spi.out_sel;
                in_sel_q  <= spi.in_sel;
                pnl_sel   <= spi.sel;
                key_stb   <= spi.key;
                pnl_rst   <= spi.rst_cmd;
                if (spi.key)
                    key_code <= spi.kbd_received ? spi.keypad : kbd_q;
            end else if (state != IDLE && spi.spi_start) begin
                out_sel_q <= 4'h0;
                in_sel_q  <= 4'h0;
            end
            if (state == LOAD) spi.data_out <= ld_byte;
            if (state == PAYLOAD && state_nx == COMMIT) begin
                wr_stb  <= 1'b1;
                wr_ch   <= in_sel_q;
                wr_data <= spi.data_in;
            end
        end
    end

`ifdef SPI_CTRL_ABORT_CNT_EN
    logic abort;

    // a restart is not an abort; data_received in PAYLOAD commits instead
    assign abort = spi.spi_end && !spi.spi_start &&
                   (state == HDR || state == LOAD ||
                    (state == PAYLOAD && !spi.data_received));

    always_ff @(posedge clk) begin
        if (reset)
            abort_cnt <= 8'h00;
        else if (abort && abort_cnt != 8'hFF)
            abort_cnt <= abort_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_spi_panel_ctrl.sv
// Directed bench for spi_panel_ctrl with load/write scoreboard queues.
// Abort counter checks follow SPI_CTRL_ABORT_CNT_EN.
module tb_spi_panel_ctrl;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   ch_valid;
    logic [8*NCH-1:0] ch_data;
    logic [NCH-1:0]   ch_ack;
    logic             wr_stb;
    logic [3:0]       wr_ch;
    logic [7:0]       wr_data;
    logic             key_stb;
    logic [4:0]       key_code;
    logic             pnl_rst;
    logic             pnl_sel;
    logic             busy;
`ifdef SPI_CTRL_ABORT_CNT_EN
    logic [7:0]       abort_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int wr_seen = 0;
    int wr_before;
    logic [7:0]  exp_load[$];
    logic [11:0] exp_wr[$];
    logic        dr_prev = 1'b0;

    always #5 clk = ~clk;

    spi_panel_ctrl_if bus ();

    spi_panel_ctrl #(.NCH(NCH)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi      (bus),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ack   (ch_ack),
        .wr_stb   (wr_stb),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .key_stb  (key_stb),
        .key_code (key_code),
        .pnl_rst  (pnl_rst),
        .pnl_sel  (pnl_sel),
        .busy     (busy)
`ifdef SPI_CTRL_ABORT_CNT_EN
        ,
        .abort_cnt(abort_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // data_out is checked when data_ready rises, writes on every wr_stb
    always @(negedge clk) begin
        if (bus.data_ready && !dr_prev) begin
            if (exp_load.size() > 0)
                chk("data_out", 32'(bus.data_out), 32'(exp_load.pop_front()));
            else
                chk("load_unexpected", 32'(exp_load.size()), 32'd1);
        end
        if (wr_stb) begin
            wr_seen++;
            if (exp_wr.size() > 0)
                chk("wr_ch_data", 32'({wr_ch, wr_data}), 32'(exp_wr.pop_front()));
            else
                chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        end
        dr_prev = bus.data_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.spi_start = 1'b1;
        tick();
        bus.spi_start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.spi_end = 1'b1;
        tick();
        bus.spi_end = 1'b0;
    endtask

    task automatic set_kbd(input logic [4:0] kp);
        bus.keypad       = kp;
        bus.kbd_received = 1'b1;
        tick();
        bus.kbd_received = 1'b0;
    endtask

    task automatic hdr(input logic [3:0] os, input logic [3:0] is,
                       input logic k, input logic r, input logic s);
        bus.out_sel      = os;
        bus.in_sel       = is;
        bus.key          = k;
        bus.rst_cmd      = r;
        bus.sel          = s;
        bus.pnl_received = 1'b1;
        tick();
        bus.pnl_received = 1'b0;
    endtask

    task automatic run_frame(input logic use_start, input logic [3:0] os,
                             input logic [3:0] is, input logic [7:0] exp_do,
                             input logic [NCH-1:0] exp_ack,
                             input logic [7:0] din);
        if (use_start) begin
            pulse_start();
            chk("busy_hdr", 32'(busy), 32'd1);
        end
        exp_load.push_back(exp_do);
        hdr(os, is, 1'b0, 1'b0, 1'b1);
        chk("ack_load", 32'(ch_ack), 32'(exp_ack));
        chk("dready_load", 32'(bus.data_ready), 32'd0);
        chk("pnl_sel", 32'(pnl_sel), 32'd1);
        tick();
        chk("dready_payload", 32'(bus.data_ready), 32'd1);
        chk("ack_clear", 32'(ch_ack), 32'd0);
        bus.data_in       = din;
        bus.data_received = 1'b1;
        exp_wr.push_back({is, din});
        tick();
        bus.data_received = 1'b0;
        chk("wr_stb_commit", 32'(wr_stb), 32'd1);
        tick();
        chk("idle_after_commit", 32'({busy, wr_stb}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.spi_start     = 1'b0;
        bus.spi_end       = 1'b0;
        bus.kbd_received  = 1'b0;
        bus.pnl_received  = 1'b0;
        bus.data_received = 1'b0;
        bus.keypad        = 5'h00;
        bus.out_sel       = 4'h0;
        bus.in_sel        = 4'h0;
        bus.key           = 1'b0;
        bus.rst_cmd       = 1'b0;
        bus.sel           = 1'b0;
        bus.data_in       = 8'h00;
        ch_valid          = '0;
        ch_data           = 32'h775A_3344;
        tick();
        tick();
        chk("reset_outs", 32'({busy, wr_stb, bus.data_ready, pnl_sel,
                               key_stb, pnl_rst, ch_ack, bus.data_out}), 32'd0);
        chk("reset_key_code", 32'(key_code), 32'd0);
`ifdef SPI_CTRL_ABORT_CNT_EN
        chk("abort_cnt_reset", 32'(abort_cnt), 32'd0);
`endif
        reset = 1'b0;
        tick();

        set_kbd(5'h0A);
        ch_valid = 4'b0100;
        run_frame(1'b1, 4'd2, 4'd1, 8'h5A, 4'b0100, 8'hC3);
        ch_valid = 4'b0111;
        run_frame(1'b1, 4'd3, 4'd2, 8'h00, 4'b0000, 8'h11);
        ch_valid = 4'b1111;
        run_frame(1'b1, 4'd9, 4'd12, 8'h00, 4'b0000, 8'h22);
        ch_valid = 4'b1000;
        run_frame(1'b0, 4'd3, 4'd0, 8'h77, 4'b1000, 8'h33);

        // keypad event and panel reset, then abort in PAYLOAD
        ch_valid = 4'b0000;
        set_kbd(5'h13);
        pulse_start();
        exp_load.push_back(8'h00);
        hdr(4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("key_pulse", 32'({key_stb, pnl_rst, pnl_sel}), 32'b110);
        chk("key_code", 32'(key_code), 32'h13);
        tick();
        chk("key_pulse_end", 32'({key_stb, pnl_rst}), 32'd0);
        chk("dready_pre_abort", 32'(bus.data_ready), 32'd1);
        wr_before = wr_seen;
        pulse_end();
        chk("abort_idle", 32'({busy, bus.data_ready}), 32'd0);
        tick();
        chk("abort_no_wr", 32'(wr_seen), 32'(wr_before));
`ifdef SPI_CTRL_ABORT_CNT_EN
        chk("abort_cnt_one", 32'(abort_cnt), 32'd1);
`endif

        // data_received in HDR is ignored; data and spi_end together commit
        pulse_start();
        bus.data_received = 1'b1;
        tick();
        bus.data_received = 1'b0;
        chk("hdr_ignore_data", 32'({busy, wr_stb}), 32'b10);
        exp_load.push_back(8'h00);
        hdr(4'd1, 4'd5, 1'b0, 1'b0, 1'b1);
        tick();
        bus.data_in       = 8'h5C;
        bus.data_received = 1'b1;
        bus.spi_end       = 1'b1;
        exp_wr.push_back({4'd5, 8'h5C});
        tick();
        bus.data_received = 1'b0;
        bus.spi_end       = 1'b0;
        chk("data_wins_wr", 32'(wr_stb), 32'd1);
        tick();
`ifdef SPI_CTRL_ABORT_CNT_EN
        chk("abort_cnt_data_wins", 32'(abort_cnt), 32'd1);
`endif

        // restart from PAYLOAD, then reset in PAYLOAD
        pulse_start();
        exp_load.push_back(8'h00);
        hdr(4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        tick();
        pulse_start();
        chk("restart_hdr", 32'({busy, bus.data_ready}), 32'b10);
        ch_valid = 4'b0100;
        exp_load.push_back(8'h5A);
        hdr(4'd2, 4'd1, 1'b0, 1'b0, 1'b1);
        chk("ack_after_restart", 32'(ch_ack), 32'b0100);
        tick();
        wr_before = wr_seen;
        reset             = 1'b1;
        bus.data_received = 1'b1;
        tick();
        reset             = 1'b0;
        bus.data_received = 1'b0;
        chk("reset_payload", 32'({busy, bus.data_ready, wr_stb, pnl_sel,
                                  bus.data_out}), 32'd0);
        tick();
        chk("reset_no_wr", 32'(wr_seen), 32'(wr_before));

`ifdef SPI_CTRL_ABORT_CNT_EN
        chk("abort_cnt_cleared", 32'(abort_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            pulse_start();
            pulse_end();
        end
        chk("abort_cnt_sat", 32'(abort_cnt), 32'hFF);
`endif

        chk("queues_drained", 32'(exp_load.size() + exp_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
